hamming_enc_stage: RTL and testbench

Upstream feeder for the modulator/demodulator chain. Accepts 16-bit payload words over a valid/ready handshake and encodes each one into a 21-bit Hamming(21,16) single-error-correcting codeword. Codewords are buffered in a small FIFO and presented to the modulator input over a second valid/ready handshake. The block decouples the payload source from modulator back-pressure.

---
 rtl/hamming_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/hamming_enc_stage.sv | 68 ++++++
 tb/tb_hamming_enc_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) definitions: widths, types and the encoder function
// used by both the encoder stage and the downstream decoder.
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CODE_W = 21;
  localparam int PAR_W  = 5;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;

  // Position p (1..21) maps to code[p-1]; powers of two hold parity, the rest
  // take data bits in ascending order.
  function automatic code_t hamming_encode(input data_t data);
    code_t code;
    int    di;
    logic  par;
    code = '0;
    di   = 0;
    for (int p = 1; p <= CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        code[5'(p - 1)] = data[4'(di)];
        di++;
      end else begin
        code[5'(p - 1)] = 1'b0;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int p = 1; p <= CODE_W; p++) begin
        par = par ^ ((((p >> k) & 1) != 0) ? code[5'(p - 1)] : 1'b0);
      end
      code[5'((1 << k) - 1)] = par;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == CNT_W'(0));
  assign do_wr_s = wr_en && !full_s;
  assign do_rd_s = rd_en && !empty_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr_s && !rst) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_r;

endmodule

// File: rtl/hamming_enc_stage.sv
// Hamming(21,16) encoder feeding a codeword FIFO towards the modulator.
// Optional error injection on the stored codeword: HAMMING_ERR_INJ_EN.
module hamming_enc_stage
  import hamming_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [20:0]                     out_code,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef HAMMING_ERR_INJ_EN
  input  logic                            inj_en,
  input  logic [4:0]                      inj_pos,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  code_t code_s;
  code_t flip_s;
  code_t stored_s;
  logic  push_s;
  logic  pop_s;
  logic  full_s;
  logic  empty_s;

  assign code_s = hamming_encode(in_data);

`ifdef HAMMING_ERR_INJ_EN
  // Positions outside 1..21 leave the codeword untouched.
  always_comb begin
    flip_s = '0;
    if (inj_en && (inj_pos != 5'd0) && (inj_pos <= 5'd21)) begin
      flip_s = 21'd1 << (inj_pos - 5'd1);
    end else begin
      flip_s = '0;
    end
  end
`else
  assign flip_s = '0;
`endif

  assign stored_s  = code_s ^ flip_s;
  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data (stored_s),
    .rd_en   (pop_s),
    .rd_data (out_code),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_hamming_enc_stage.sv
// Directed self-checking bench for hamming_enc_stage; expected codewords are
// hand-computed, with a per-bit table model for the back-pressure run.
module tb_hamming_enc_stage;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] out_code;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;
`ifdef HAMMING_ERR_INJ_EN
  logic        inj_en;
  logic [4:0]  inj_pos;
`endif

  int n_compared;
  int n_mismatched;

  hamming_enc_stage #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef HAMMING_ERR_INJ_EN
    .inj_en     (inj_en),
    .inj_pos    (inj_pos),
`endif
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived codeword of each single data bit; encoding is linear.
  logic [20:0] bit_code [16];
  initial begin
    bit_code[0]  = 21'h000007; bit_code[1]  = 21'h000019;
    bit_code[2]  = 21'h00002A; bit_code[3]  = 21'h00004B;
    bit_code[4]  = 21'h000181; bit_code[5]  = 21'h000282;
    bit_code[6]  = 21'h000483; bit_code[7]  = 21'h000888;
    bit_code[8]  = 21'h001089; bit_code[9]  = 21'h00208A;
    bit_code[10] = 21'h00408B; bit_code[11] = 21'h018001;
    bit_code[12] = 21'h028002; bit_code[13] = 21'h048003;
    bit_code[14] = 21'h088008; bit_code[15] = 21'h108009;
  end

  function automatic logic [20:0] model_code(input logic [15:0] d);
    logic [20:0] c;
    c = 21'h0;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) c = c ^ bit_code[i];
    end
    return c;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one word, check it one cycle later, then pop it.
  task automatic push_pop_one(input logic [15:0] d, input logic [20:0] exp, input string tag);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_value({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_value({tag, "_code"}, 32'(out_code), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_value({tag, "_cnt"}, 32'(fifo_count), 32'd0);
  endtask

  logic [15:0] rnd_words [$];
  logic [20:0] sb [$];
  logic [20:0] prev_code;
  logic        prev_stall;
  int          cyc;
  logic        do_push;
  logic        do_pop;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    in_data   = 16'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef HAMMING_ERR_INJ_EN
    inj_en    = 1'b0;
    inj_pos   = 5'd0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_value("rst_cnt", 32'(fifo_count), 32'd0);
    check_value("rst_valid", 32'(out_valid), 32'd0);
    check_value("rst_ready", 32'(in_ready), 32'd1);

    push_pop_one(16'h0001, 21'h000007, "w0001");
    push_pop_one(16'hFFFF, 21'h1FFFFE, "wFFFF");
    push_pop_one(16'h0000, 21'h000000, "w0000");
    push_pop_one(16'h8000, 21'h108009, "w8000");
    push_pop_one(16'h0003, 21'h00001E, "w0003");
    push_pop_one(16'h0012, 21'h000198, "w0012");

    // Fill to full with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h0002; @(negedge clk);
    in_data = 16'h0004; @(negedge clk);
    in_data = 16'h0008; @(negedge clk);
    in_data = 16'h0010; @(negedge clk);
    check_value("full_cnt", 32'(fifo_count), 32'd4);
    check_value("full_ready", 32'(in_ready), 32'd0);
    in_data = 16'h8000; @(negedge clk);
    in_valid = 1'b0;
    check_value("full_reject_cnt", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    check_value("drain0", 32'(out_code), 32'h000019); @(negedge clk);
    check_value("drain1", 32'(out_code), 32'h00002A); @(negedge clk);
    check_value("drain2", 32'(out_code), 32'h00004B); @(negedge clk);
    check_value("drain3", 32'(out_code), 32'h000181); @(negedge clk);
    out_ready = 1'b0;
    check_value("drain_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count 2.
    in_valid = 1'b1;
    in_data = 16'h0020; @(negedge clk);
    in_data = 16'h0040; @(negedge clk);
    check_value("sim_cnt_pre", 32'(fifo_count), 32'd2);
    in_data   = 16'h0080;
    out_ready = 1'b1;
    check_value("sim_head0", 32'(out_code), 32'h000282);
    @(negedge clk);
    in_valid = 1'b0;
    check_value("sim_cnt_post", 32'(fifo_count), 32'd2);
    check_value("sim_head1", 32'(out_code), 32'h000483); @(negedge clk);
    check_value("sim_head2", 32'(out_code), 32'h000888); @(negedge clk);
    out_ready = 1'b0;
    check_value("sim_empty", 32'(fifo_count), 32'd0);

    // Random back-pressure against the table model.
    rnd_words = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA,
                  16'h8001, 16'h7FFE, 16'hC3A5, 16'h0100, 16'hFFFF, 16'h0000};
    prev_stall = 1'b0;
    prev_code  = 21'h0;
    cyc = 0;
    while ((rnd_words.size() != 0 || sb.size() != 0) && cyc < 300) begin
      if (prev_stall) check_value("bp_stable", 32'(out_code), 32'(prev_code));
      if (out_valid) begin
        if (sb.size() != 0) check_value("bp_code", 32'(out_code), 32'(sb[0]));
        else check_value("bp_spurious_valid", 32'(out_valid), 32'd0);
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (rnd_words.size() != 0);
      in_data   = (rnd_words.size() != 0) ? rnd_words[0] : 16'h0;
      do_push   = in_valid && in_ready;
      do_pop    = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_code  = out_code;
      if (do_pop && sb.size() != 0) void'(sb.pop_front());
      if (do_push) sb.push_back(model_code(rnd_words.pop_front()));
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_value("bp_timeout", 32'(cyc < 300), 32'd1);
    check_value("bp_final_cnt", 32'(fifo_count), 32'd0);

    // Reset with three entries queued.
    in_valid = 1'b1;
    in_data = 16'h0001; @(negedge clk);
    in_data = 16'h0002; @(negedge clk);
    in_data = 16'h0004; @(negedge clk);
    check_value("mid_cnt_pre", 32'(fifo_count), 32'd3);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_value("mid_valid", 32'(out_valid), 32'd0);
    check_value("mid_cnt", 32'(fifo_count), 32'd0);
    check_value("mid_ready", 32'(in_ready), 32'd1);
    push_pop_one(16'h0100, 21'h001089, "post_rst");

`ifdef HAMMING_ERR_INJ_EN
    inj_en = 1'b1;
    inj_pos = 5'd21;
    push_pop_one(16'h0001, 21'h100007, "inj21");
    inj_pos = 5'd0;
    push_pop_one(16'h0001, 21'h000007, "inj0");
    inj_pos = 5'd22;
    push_pop_one(16'h0001, 21'h000007, "inj22");
    inj_pos = 5'd1;
    push_pop_one(16'h0001, 21'h000006, "inj1");
    inj_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
